// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle MIPS control FSM and its
// datapath.
//   master : the controller. It takes opcode/funct/zero and drives every
//            enable, mux select, alu_op and the two retire pulses.
//   slave  : the datapath. It drives opcode/funct (from IR) and zero (from the
//            ALU), and takes the control outputs.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct, zero,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath. It sequences
// fetch/decode/execute/memory/writeback for each instruction from the IR
// opcode/funct and the ALU zero flag, and drives every datapath enable and mux
// select. It also produces the 3-bit ALUOp code that the ALU consumes.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous, active-low reset
//   bus    : multicycle_controller_if.master
//            inputs  : opcode, funct, zero
//            outputs : pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
//                      mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
//                      pc_src, instr_done, illegal
//
// Parameter
//   IDLE_CYCLES : number of IDLE clocks after reset before the first FETCH
//                 (legal range 1..15)
//
// Build option
//   JAL_EN : when defined, opcode 0x03 (jal) is supported. When it is not
//            defined, 0x03 decodes as illegal.
module multicycle_controller #(
  parameter int unsigned IDLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_controller_if.master  bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
`ifdef JAL_EN
  localparam logic [5:0] OP_JAL   = 6'h03;
`endif
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [3:0] IDLE_LAST = 4'(IDLE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_R_EXEC,
    S_R_WB,
    S_BRANCH,
    S_JUMP,
    S_ADDI_EXEC,
    S_ADDI_WB
`ifdef JAL_EN
    , S_JAL
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic [2:0] r_op_q, r_op_d;
  logic       done_q, done_d;
  logic       illegal_q, illegal_d;

  logic       funct_ok;
  logic [2:0] funct_op;
  logic       pc_uncond;

  // R-type funct decode into an ALU operation.
  always_comb begin
    funct_ok = 1'b1;
    funct_op = ALU_ADD;
    case (bus.funct)
      6'h20:   funct_op = ALU_ADD;
      6'h22:   funct_op = ALU_SUB;
      6'h24:   funct_op = ALU_AND;
      6'h25:   funct_op = ALU_OR;
      6'h2A:   funct_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
      r_op_q     <= ALU_ADD;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      r_op_q     <= r_op_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  // Next-state logic and the retire/drop pulse requests.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    r_op_d     = r_op_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (idle_cnt_q == IDLE_LAST) begin
          state_d    = S_FETCH;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 4'd1;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_R_EXEC;
              // Latch the R-type op here so R_WB holds the same alu_op.
              r_op_d  = funct_op;
            end else begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          end
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
`ifdef JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB
`ifdef JAL_EN
      , S_JAL
`endif
      : begin
        state_d = S_FETCH;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register. pc_write alone also
  // depends on zero, and only while in BRANCH.
  always_comb begin
    pc_uncond      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 2'b00;
    bus.mem_to_reg = 2'b00;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = ALU_ADD;
    bus.pc_src     = 2'b00;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.ir_write  = 1'b1;
        pc_uncond     = 1'b1;
        bus.alu_src_b = 2'b01;
      end
      S_DECODE: bus.alu_src_b = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
      end
      S_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = r_op_q;
      end
      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'b01;
        bus.alu_op    = r_op_q;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = 2'b01;
      end
      S_JUMP: begin
        pc_uncond  = 1'b1;
        bus.pc_src = 2'b10;
      end
      S_ADDI_WB: bus.reg_write = 1'b1;
`ifdef JAL_EN
      S_JAL: begin
        pc_uncond      = 1'b1;
        bus.pc_src     = 2'b10;
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'b10;
        bus.mem_to_reg = 2'b10;
      end
`endif
      default: ;
    endcase
    bus.pc_write = pc_uncond | ((state_q == S_BRANCH) & bus.zero);
  end

  assign bus.instr_done = done_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Each step compares the complete
// output word with a hand-built expected word.
module tb_multicycle_controller;
  logic clk;
  logic rst_n;
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  multicycle_controller_if bus();

  multicycle_controller #(.IDLE_CYCLES(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of run, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  // Packed output word, ordered
  // {pw, iord, mr, mw, irw, rd, mtr, rw, sa, sb, op, ps, done, ill}.
  function automatic logic [19:0] pk(input logic pw, input logic iord, input logic mr,
                                     input logic mw, input logic irw, input logic [1:0] rd,
                                     input logic [1:0] mtr, input logic rw, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] op,
                                     input logic [1:0] ps, input logic dn, input logic il);
    return {pw, iord, mr, mw, irw, rd, mtr, rw, sa, sb, op, ps, dn, il};
  endfunction

  function automatic logic [19:0] sig();
    return {bus.pc_write, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.instr_done, bus.illegal};
  endfunction

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run from the current FETCH until the next retire/drop pulse. The run is
  // bounded to 16 cycles, and a timeout shows up as a latency miscompare.
  task automatic run_instr(input string tag, input int unsigned lat);
    int unsigned n = 0;
    bit seen = 1'b0;
    while (!seen && n < 16) begin
      tick();
      n++;
      if (bus.instr_done || bus.illegal) seen = 1'b1;
      else check({tag, "_irw"}, 20'(bus.ir_write), 20'd0);
    end
    check({tag, "_lat"}, 20'(n), 20'(lat));
    check({tag, "_end"}, {17'd0, bus.ir_write, bus.instr_done, bus.illegal}, 20'b110);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.opcode = 6'h00;
    bus.funct  = 6'h00;
    bus.zero   = 1'b0;

    #3 check("reset", sig(), '0);
    tick();
    check("reset_hold", sig(), '0);

    // lw: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, then a FETCH with done
    bus.opcode = 6'h23;
    rst_n      = 1'b1;
    tick(); check("lw_fetch",   sig(), pk(1,0,1,0,1,2'd0,2'd0,0,0,2'd1,3'd0,2'd0,0,0));
    tick(); check("lw_decode",  sig(), pk(0,0,0,0,0,2'd0,2'd0,0,0,2'd3,3'd0,2'd0,0,0));
    tick(); check("lw_maddr",   sig(), pk(0,0,0,0,0,2'd0,2'd0,0,1,2'd2,3'd0,2'd0,0,0));
    tick(); check("lw_mread",   sig(), pk(0,1,1,0,0,2'd0,2'd0,0,0,2'd0,3'd0,2'd0,0,0));
    tick(); check("lw_wb",      sig(), pk(0,0,0,0,0,2'd0,2'd1,1,0,2'd0,3'd0,2'd0,0,0));
    tick(); check("lw_done",    sig(), pk(1,0,1,0,1,2'd0,2'd0,0,0,2'd1,3'd0,2'd0,1,0));

    // second lw, with reset asserted in the middle of MEM_READ
    tick(); tick(); tick();
    check("lw2_mread", sig(), pk(0,1,1,0,0,2'd0,2'd0,0,0,2'd0,3'd0,2'd0,0,0));
    #2 rst_n = 1'b0;
    #1 check("async_reset", sig(), '0);
    tick(); check("async_reset_hold", sig(), '0);
    rst_n      = 1'b1;
    bus.opcode = 6'h00;
    bus.funct  = 6'h2A;
    tick(); check("rst_fetch", sig(), pk(1,0,1,0,1,2'd0,2'd0,0,0,2'd1,3'd0,2'd0,0,0));

    // R-type slt
    tick(); check("slt_decode", sig(), pk(0,0,0,0,0,2'd0,2'd0,0,0,2'd3,3'd0,2'd0,0,0));
    tick(); check("slt_exec",   sig(), pk(0,0,0,0,0,2'd0,2'd0,0,1,2'd0,3'd4,2'd0,0,0));
    tick(); check("slt_wb",     sig(), pk(0,0,0,0,0,2'd1,2'd0,1,0,2'd0,3'd4,2'd0,0,0));
    tick(); check("slt_done",   sig(), pk(1,0,1,0,1,2'd0,2'd0,0,0,2'd1,3'd0,2'd0,1,0));

    // R-type with the unsupported funct 0x27 (nor): dropped, no reg_write
    bus.funct = 6'h27;
    tick(); check("nor_decode", sig(), pk(0,0,0,0,0,2'd0,2'd0,0,0,2'd3,3'd0,2'd0,0,0));
    tick(); check("nor_ill",    sig(), pk(1,0,1,0,1,2'd0,2'd0,0,0,2'd1,3'd0,2'd0,0,1));

    // beq taken; a change on zero during DECODE must have no effect
    bus.opcode = 6'h04;
    tick(); check("beq_decode", sig(), pk(0,0,0,0,0,2'd0,2'd0,0,0,2'd3,3'd0,2'd0,0,0));
    bus.zero = 1'b1;
    #1 check("beq_decode_z", sig(), pk(0,0,0,0,0,2'd0,2'd0,0,0,2'd3,3'd0,2'd0,0,0));
    tick(); check("beq_taken",  sig(), pk(1,0,0,0,0,2'd0,2'd0,0,1,2'd0,3'd1,2'd1,0,0));
    bus.zero = 1'b0;
    #1 check("beq_zdrop",   sig(), pk(0,0,0,0,0,2'd0,2'd0,0,1,2'd0,3'd1,2'd1,0,0));
    tick(); check("beq_done",   sig(), pk(1,0,1,0,1,2'd0,2'd0,0,0,2'd1,3'd0,2'd0,1,0));

    // beq not taken
    tick(); tick();
    check("beqn_branch", sig(), pk(0,0,0,0,0,2'd0,2'd0,0,1,2'd0,3'd1,2'd1,0,0));
    tick(); check("beqn_done", sig(), pk(1,0,1,0,1,2'd0,2'd0,0,0,2'd1,3'd0,2'd0,1,0));

    // opcode 0x03
    bus.opcode = 6'h03;
    tick(); check("jal_decode", sig(), pk(0,0,0,0,0,2'd0,2'd0,0,0,2'd3,3'd0,2'd0,0,0));
`ifdef JAL_EN
    tick(); check("jal_exec",   sig(), pk(1,0,0,0,0,2'd2,2'd2,1,0,2'd0,3'd0,2'd2,0,0));
    tick(); check("jal_done",   sig(), pk(1,0,1,0,1,2'd0,2'd0,0,0,2'd1,3'd0,2'd0,1,0));
`else
    tick(); check("jal_ill",    sig(), pk(1,0,1,0,1,2'd0,2'd0,0,0,2'd1,3'd0,2'd0,0,1));
`endif

    // back-to-back j, addi, sw
    bus.opcode = 6'h02;
    run_instr("j", 3);
    bus.opcode = 6'h08;
    run_instr("addi", 4);
    bus.opcode = 6'h2B;
    run_instr("sw", 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
